// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage next-PC sequencer.
// Holds the debug FSM state encoding, the alignment mask and the reset/step defaults.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } seq_state_e;

  localparam logic [1:0]  PC_ALIGN_MASK        = 2'b11;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEFAULT_PC_STEP      = 4;

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-PC priority select: jump > branch > hazard stall > sequential.
// Redirect targets are word-aligned; misalign_o flags dropped low bits, redirect still proceeds.
module next_pc_mux
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic [PC_WIDTH-1:0] pc_current_i,
  input  logic                hazard_stall_i,
  input  logic                branch_taken_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  input  logic                jump_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  output logic [PC_WIDTH-1:0] pc_next_o,
  output logic                pc_write_en_o,
  output logic                flush_o,
  output logic                misalign_o,
  output logic                redirect_o
);

  logic [PC_WIDTH-1:0] sel_target;

  always_comb begin
    redirect_o    = jump_i | branch_taken_i;
    sel_target    = jump_i ? jump_target_i : branch_target_i;
    pc_next_o     = pc_current_i;
    pc_write_en_o = 1'b1;
    flush_o       = 1'b0;
    misalign_o    = 1'b0;
    if (redirect_o) begin
      // Redirects beat a hazard stall: the stalled instruction is on the wrong path anyway.
      pc_next_o  = sel_target & ~PC_WIDTH'(PC_ALIGN_MASK);
      flush_o    = 1'b1;
      misalign_o = |(sel_target[1:0] & PC_ALIGN_MASK);
    end else if (hazard_stall_i) begin
      pc_write_en_o = 1'b0;
    end else begin
      pc_next_o = pc_current_i + PC_WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC controller with BOOT/RUN/HALT/STEP debug FSM; outputs are combinational from state.
// Optional FETCH_COUNTER_EN adds a 32-bit count of cycles that actually advance fetch.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int                  PC_STEP      = DEFAULT_PC_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] pc_current_i,
  input  logic                hazard_stall_i,
  input  logic                branch_taken_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  input  logic                jump_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  input  logic                halt_req_i,
  input  logic                resume_req_i,
  input  logic                step_req_i,
  output logic [PC_WIDTH-1:0] pc_next_o,
  output logic                pc_write_en_o,
  output logic                global_stall_o,
  output logic                flush_o,
  output logic                halted_o,
  output logic                misalign_o,
  output logic [31:0]         fetch_count_o
);

  seq_state_e          state_q;
  logic                halt_pending_q;

  logic [PC_WIDTH-1:0] mux_pc_next;
  logic                mux_write_en;
  logic                mux_flush;
  logic                mux_misalign;
  logic                mux_redirect;

  next_pc_mux #(
    .PC_WIDTH (PC_WIDTH),
    .PC_STEP  (PC_STEP)
  ) u_next_pc_mux (
    .pc_current_i    (pc_current_i),
    .hazard_stall_i  (hazard_stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .pc_next_o       (mux_pc_next),
    .pc_write_en_o   (mux_write_en),
    .flush_o         (mux_flush),
    .misalign_o      (mux_misalign),
    .redirect_o      (mux_redirect)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= BOOT;
      halt_pending_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          // A redirect in flight finishes first; the halt lands on the next quiet cycle.
          if ((halt_pending_q || halt_req_i) && !mux_redirect) begin
            state_q        <= HALT;
            halt_pending_q <= 1'b0;
          end else if (halt_req_i) begin
            halt_pending_q <= 1'b1;
          end
        end
        HALT: begin
          if (resume_req_i)    state_q <= RUN;
          else if (step_req_i) state_q <= STEP;
        end
        STEP:    state_q <= HALT;
        default: state_q <= BOOT;
      endcase
    end
  end

  always_comb begin
    pc_next_o      = RESET_VECTOR;
    pc_write_en_o  = 1'b0;
    global_stall_o = 1'b1;
    flush_o        = 1'b0;
    halted_o       = 1'b0;
    misalign_o     = 1'b0;
    if (rst_n) begin
      case (state_q)
        BOOT: begin
          pc_write_en_o  = 1'b1;
          flush_o        = 1'b1;
          global_stall_o = 1'b0;
        end
        RUN, STEP: begin
          pc_next_o      = mux_pc_next;
          pc_write_en_o  = mux_write_en;
          flush_o        = mux_flush;
          misalign_o     = mux_misalign;
          global_stall_o = 1'b0;
        end
        HALT: begin
          pc_next_o = pc_current_i;
          halted_o  = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_COUNTER_EN
  logic [31:0] fetch_count_q;
  logic [31:0] fetch_count_d;

  assign fetch_count_d = fetch_count_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_q <= 32'd0;
    end else if (pc_write_en_o && !global_stall_o) begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count_o = fetch_count_q;
`else
  assign fetch_count_o = 32'd0;
`endif

endmodule
